// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 control unit: opcodes, FSM states,
// datapath mux selects, ALU-op classes and fault codes.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_RT   = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BEQ, S_JAL, S_FAULT
  } state_e;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_ILLEGAL = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT = 2'b10;

  // Wait counter width; a disabled timeout still needs a 1-bit vector.
  function automatic int wait_cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles spent waiting for mem_ready in a memory-wait state
// and flags the cycle on which the wait budget runs out.
module mem_wait_timer
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active_i,
  input  logic ready_i,
  output logic timeout_o
);

  localparam int CW = wait_cnt_width(MEM_TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt_q, cnt_d;

  // Held at zero outside wait states, so every entry starts from zero;
  // a completed request also clears it.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!active_i || ready_i) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  if (MEM_TIMEOUT > 0) begin : g_timeout
    assign timeout_o = active_i && !ready_i && (cnt_q == LAST);
  end else begin : g_no_timeout
    assign timeout_o = 1'b0;
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32 control FSM: sequences each instruction through
// fetch/decode/execute/memory/writeback and drives the shared datapath.
//
// state    | meaning
// RESET    | post-reset idle cycle, no outputs
// FETCH    | read instruction at PC, PC += 4 when memory completes
// DECODE   | compute branch target (oldPC + imm), dispatch on opcode
// MEMADR   | compute rs1 + imm for load/store
// MEMREAD  | load request at computed address
// MEMWB    | write loaded data to rd
// MEMWRITE | store request at computed address
// EXEC_R   | register-register ALU op
// EXEC_I   | register-immediate ALU op
// ALUWB    | write ALU result register to rd
// BEQ      | compare rs1/rs2, PC <= target if zero
// JAL      | PC <= target, ALU computes oldPC + 4 for rd
// FAULT    | terminal until reset, only fault code driven
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 7,
  parameter int ALUOP_W     = 2,
  parameter bit SUPPORT_JAL = 1'b1,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                adr_src,
  output logic                ir_write,
  output logic                pc_write,
  output logic                branch,
  output logic                reg_write,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          result_src,
  output logic [ALUOP_W-1:0]  aluop,
  output logic                instr_done,
  output logic [1:0]          fault
);

  state_e     state_q, state_d;
  logic [1:0] fault_q, fault_d;
  logic [1:0] aluop_c;
  logic [6:0] op7;
  logic       wait_active, timeout;

  assign op7         = opcode[6:0];
  assign wait_active = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                       (state_q == S_MEMWRITE);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
    .clk       (clk),
    .rst_n     (rst_n),
    .active_i  (wait_active),
    .ready_i   (mem_ready),
    .timeout_o (timeout)
  );

  // State and sticky fault registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      fault_q <= FLT_NONE;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  // Next-state decode; mem_ready beats a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    if (wait_active && !mem_ready && timeout) begin
      state_d = S_FAULT;
      fault_d = FLT_TIMEOUT;
    end else begin
      case (state_q)
        S_RESET:    state_d = S_FETCH;
        S_FETCH:    if (mem_ready) state_d = S_DECODE;
        S_DECODE: begin
          case (op7)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_RT:        state_d = S_EXEC_R;
            OP_IALU:      state_d = S_EXEC_I;
            OP_BEQ:       state_d = S_BEQ;
            OP_JAL: begin
              if (SUPPORT_JAL) begin
                state_d = S_JAL;
              end else begin
                state_d = S_FAULT;
                fault_d = FLT_ILLEGAL;
              end
            end
            default: begin
              state_d = S_FAULT;
              fault_d = FLT_ILLEGAL;
            end
          endcase
        end
        S_MEMADR:   state_d = (op7 == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
        S_MEMWB:    state_d = S_FETCH;
        S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
        S_EXEC_R:   state_d = S_ALUWB;
        S_EXEC_I:   state_d = S_ALUWB;
        S_ALUWB:    state_d = S_FETCH;
        S_BEQ:      state_d = S_FETCH;
        S_JAL:      state_d = S_ALUWB;
        S_FAULT:    state_d = S_FAULT;
        default:    state_d = S_RESET;
      endcase
    end
  end

  // Moore outputs per state; FETCH IR/PC writes and the store retire pulse
  // follow mem_ready so they fire only on the completing cycle.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    result_src = RES_ALUOUT;
    aluop_c    = ALUOP_ADD;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        adr_src    = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        aluop_c   = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        aluop_c   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RS1;
        aluop_c    = ALUOP_SUB;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  assign aluop = ALUOP_W'(aluop_c);
  assign fault = fault_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

  localparam int ST_RESET = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEMADR = 3,
                 ST_MEMREAD = 4, ST_MEMWB = 5, ST_MEMWRITE = 6, ST_EXEC_R = 7,
                 ST_EXEC_I = 8, ST_ALUWB = 9, ST_BEQ = 10, ST_JAL = 11,
                 ST_FAULT = 12;

  localparam logic [6:0] RT = 7'b0110011, IALU = 7'b0010011, LW = 7'b0000011,
                         SW = 7'b0100011, BEQ = 7'b1100011, JAL = 7'b1101111,
                         FENCE = 7'b0001111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       mem_req, mem_we, adr_src, ir_write, pc_write, branch, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src, aluop, fault;
  logic       instr_done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [17:0] exp_q[$];

  multicycle_control_fsm #(
    .OPCODE_W(7), .ALUOP_W(2), .SUPPORT_JAL(1'b0), .MEM_TIMEOUT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .branch(branch),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .aluop(aluop), .instr_done(instr_done),
    .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [17:0] got_vec();
    return {mem_req, mem_we, adr_src, ir_write, pc_write, branch, reg_write,
            alu_src_a, alu_src_b, result_src, aluop, instr_done, fault};
  endfunction

  // Reference outputs per state, written from the control table.
  function automatic logic [17:0] model(input int st, input bit rdy, input logic [1:0] fc);
    logic mreq, mwe, adr, irw, pcw, br, rw, dn;
    logic [1:0] a, b, rs, op, f;
    {mreq, mwe, adr, irw, pcw, br, rw, dn} = '0;
    {a, b, rs, op, f} = '0;
    case (st)
      ST_FETCH:    begin mreq = 1; irw = rdy; pcw = rdy; b = 2'b10; rs = 2'b10; end
      ST_DECODE:   begin a = 2'b01; b = 2'b01; end
      ST_MEMADR:   begin a = 2'b10; b = 2'b01; end
      ST_MEMREAD:  begin mreq = 1; adr = 1; end
      ST_MEMWB:    begin rs = 2'b01; rw = 1; dn = 1; end
      ST_MEMWRITE: begin mreq = 1; mwe = 1; adr = 1; dn = rdy; end
      ST_EXEC_R:   begin a = 2'b10; b = 2'b00; op = 2'b10; end
      ST_EXEC_I:   begin a = 2'b10; b = 2'b01; op = 2'b10; end
      ST_ALUWB:    begin rw = 1; dn = 1; end
      ST_BEQ:      begin a = 2'b10; op = 2'b01; br = 1; dn = 1; end
      ST_JAL:      begin a = 2'b01; b = 2'b10; pcw = 1; end
      ST_FAULT:    begin f = fc; end
      default: ;
    endcase
    return {mreq, mwe, adr, irw, pcw, br, rw, a, b, rs, op, dn, f};
  endfunction

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock: drive mem_ready, queue the expected outputs, then sample and compare.
  task automatic cyc(input int st, input bit rdy, input logic [1:0] fc, input string tag);
    logic [17:0] e, g;
    @(negedge clk);
    mem_ready = rdy;
    exp_q.push_back(model(st, rdy, fc));
    #1;
    g = got_vec();
    e = exp_q.pop_front();
    done_cnt += int'(instr_done);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s state%0d: got %b expected %b", tag, st, g, e);
    end
  endtask

  task automatic check_done(input int start, input int n, input string tag);
    checks++;
    if (done_cnt - start !== n) begin
      errors++;
      $display("FAIL %s instr_done count: got %0d expected %0d", tag, done_cnt - start, n);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (got_vec() !== 18'd0) begin
      errors++;
      $display("FAIL reset_asserted: got %b expected 0", got_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (got_vec() !== 18'd0) begin
      errors++;
      $display("FAIL reset_state: got %b expected 0", got_vec());
    end
  endtask

  task automatic test_rtype();
    int s = done_cnt;
    opcode = RT;
    cyc(ST_FETCH, 1, 2'b00, "rt_fetch");
    cyc(ST_DECODE, rnd(), 2'b00, "rt_decode");
    cyc(ST_EXEC_R, rnd(), 2'b00, "rt_exec");
    cyc(ST_ALUWB, rnd(), 2'b00, "rt_wb");
    check_done(s, 1, "rtype");
  endtask

  task automatic test_lw_wait();
    int s = done_cnt;
    opcode = LW;
    cyc(ST_FETCH, 1, 2'b00, "lw_fetch");
    cyc(ST_DECODE, rnd(), 2'b00, "lw_decode");
    cyc(ST_MEMADR, rnd(), 2'b00, "lw_memadr");
    cyc(ST_MEMREAD, 0, 2'b00, "lw_read0");
    cyc(ST_MEMREAD, 0, 2'b00, "lw_read1");
    cyc(ST_MEMREAD, 0, 2'b00, "lw_read2");
    cyc(ST_MEMREAD, 1, 2'b00, "lw_read3");
    cyc(ST_MEMWB, rnd(), 2'b00, "lw_wb");
    check_done(s, 1, "lw");
  endtask

  task automatic test_back_to_back();
    int s = done_cnt;
    opcode = SW;
    cyc(ST_FETCH, 1, 2'b00, "sw_fetch");
    cyc(ST_DECODE, rnd(), 2'b00, "sw_decode");
    cyc(ST_MEMADR, rnd(), 2'b00, "sw_memadr");
    cyc(ST_MEMWRITE, 1, 2'b00, "sw_write");
    opcode = BEQ;
    cyc(ST_FETCH, 1, 2'b00, "beq_fetch");
    cyc(ST_DECODE, rnd(), 2'b00, "beq_decode");
    cyc(ST_BEQ, rnd(), 2'b00, "beq_exec");
    check_done(s, 2, "sw_beq");
  endtask

  task automatic test_illegal(input logic [6:0] op, input string tag);
    opcode = op;
    cyc(ST_FETCH, 1, 2'b00, tag);
    cyc(ST_DECODE, rnd(), 2'b00, tag);
    for (int i = 0; i < 3; i++) cyc(ST_FAULT, rnd(), 2'b01, tag);
    test_reset();
  endtask

  task automatic test_timeout();
    int s;
    opcode = IALU;
    for (int i = 0; i < 4; i++) cyc(ST_FETCH, 0, 2'b00, "to_fetch");
    cyc(ST_FAULT, 1, 2'b10, "to_fault");
    cyc(ST_FAULT, 0, 2'b10, "to_fault");
    test_reset();
    s = done_cnt;
    for (int i = 0; i < 3; i++) cyc(ST_FETCH, 0, 2'b00, "edge_fetch");
    cyc(ST_FETCH, 1, 2'b00, "edge_fetch_rdy");
    cyc(ST_DECODE, rnd(), 2'b00, "edge_decode");
    cyc(ST_EXEC_I, rnd(), 2'b00, "edge_exec_i");
    cyc(ST_ALUWB, rnd(), 2'b00, "edge_wb");
    check_done(s, 1, "ialu");
    opcode = LW;
    cyc(ST_FETCH, 1, 2'b00, "rdto_fetch");
    cyc(ST_DECODE, 0, 2'b00, "rdto_decode");
    cyc(ST_MEMADR, 0, 2'b00, "rdto_memadr");
    for (int i = 0; i < 4; i++) cyc(ST_MEMREAD, 0, 2'b00, "rdto_read");
    cyc(ST_FAULT, 0, 2'b10, "rdto_fault");
    test_reset();
  endtask

  task automatic test_reset_mid_write();
    opcode = SW;
    cyc(ST_FETCH, 1, 2'b00, "rm_fetch");
    cyc(ST_DECODE, 0, 2'b00, "rm_decode");
    cyc(ST_MEMADR, 0, 2'b00, "rm_memadr");
    cyc(ST_MEMWRITE, 0, 2'b00, "rm_write");
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we} !== 2'b00 || got_vec() !== 18'd0) begin
      errors++;
      $display("FAIL reset_mid_write: got mem_req=%b mem_we=%b all=%b expected 0",
               mem_req, mem_we, got_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (got_vec() !== 18'd0) begin
      errors++;
      $display("FAIL reset_mid_release: got %b expected 0", got_vec());
    end
    cyc(ST_FETCH, 1, 2'b00, "rm_refetch");
    cyc(ST_DECODE, 0, 2'b00, "rm_redecode");
    cyc(ST_MEMADR, 0, 2'b00, "rm_rememadr");
    cyc(ST_MEMWRITE, 1, 2'b00, "rm_rewrite");
  endtask

  initial begin
    rst_n = 1'b1;
    opcode = RT;
    mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_back_to_back();
    test_illegal(FENCE, "illegal_fence");
    test_illegal(JAL, "illegal_jal");
    test_timeout();
    test_reset_mid_write();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
